// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : serial_adder_ctrl_pkg
// Desc   : shared FSM states and sizing constants for the serial adder
// Rev    : 1.0
// ------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bit counter width for an arbitrary operand width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : full_adder
// Desc   : single-bit full adder
// Rev    : 1.0
// ------------------------------------------------------------------
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : serial_adder_ctrl
// Desc   : bit-serial adder, one shared full adder, LSB first
// Rev    : 1.0
// ------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             carry_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned C_CNT_W = cnt_width(WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

  state_e             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_res_next;

  full_adder u_fa (
    .a_i    (r_a[0]),
    .b_i    (r_b[0]),
    .cin_i  (r_carry),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_LOAD;
            r_a     <= op_a_i;
            r_b     <= op_b_i;
            r_carry <= carry_i;
            r_cnt   <= '0;
          end
        end
        ST_LOAD: r_state <= ST_RUN;
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          // Publish the result on the final bit so it is valid alongside done_o.
          if (r_cnt == C_LAST) begin
            r_state <= ST_DONE;
            r_sum   <= w_res_next;
            r_cout  <= w_cout;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (r_state != ST_IDLE);
  assign done_o  = (r_state == ST_DONE);
  assign sum_o   = r_sum;
  assign carry_o = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : tb_serial_adder_ctrl
// Desc   : self-checking bench against a transaction-timing model
// Rev    : 1.0
// ------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] op_a_i = '0;
  logic [W-1:0] op_b_i = '0;
  logic         carry_i = 1'b0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         carry_o;

  int n_err = 0;
  int n_checks = 0;

  // Model: age of the current addition in edges since acceptance, -1 when idle.
  int           m_age = -1;
  logic [W:0]   m_exp = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  int           m_dones = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .carry_i (carry_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .carry_o (carry_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".busy"},  32'(busy_o),  32'(m_age >= 0));
    chk({tag, ".done"},  32'(done_o),  32'(m_age == W + 1));
    chk({tag, ".sum"},   32'(sum_o),   32'(m_sum));
    chk({tag, ".carry"}, 32'(carry_o), 32'(m_cout));
  endtask

  // Drive inputs, clock once, advance the model, then check 1 time unit after the edge.
  task automatic step(input string tag, input logic st, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic c);
    int pre;
    start_i = st;
    op_a_i  = a;
    op_b_i  = b;
    carry_i = c;
    @(posedge clk_i);
    pre = m_age;
    if (m_age >= 0) begin
      m_age++;
      if (m_age == W + 2) m_age = -1;
    end
    if (pre < 0 && st) begin
      m_age = 0;
      m_exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    end
    if (m_age == W + 1) begin
      m_sum  = m_exp[W-1:0];
      m_cout = m_exp[W];
      m_dones++;
    end
    #1;
    chk_outputs(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < W + 3; i++) step(tag, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic model_reset();
    m_age  = -1;
    m_sum  = '0;
    m_cout = 1'b0;
  endtask

  initial begin
    int dones_before;

    // Reset state
    #12;
    chk_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 5+3: busy edges 0..4, done on edge 5
    step("add5_3", 1'b1, 4'd5, 4'd3, 1'b0);
    for (int i = 1; i <= 6; i++) step("add5_3", 1'b0, 4'd0, 4'd0, 1'b0);
    chk("add5_3.result", 32'({carry_o, sum_o}), 32'd8);

    step("add15_1", 1'b1, 4'd15, 4'd1, 1'b0);
    drain("add15_1");
    chk("add15_1.result", 32'({carry_o, sum_o}), 32'h10);
    step("add15_15_1", 1'b1, 4'd15, 4'd15, 1'b1);
    drain("add15_15_1");
    chk("add15_15_1.result", 32'({carry_o, sum_o}), 32'h1f);

    // Restarts with changed operands during a busy addition are ignored
    dones_before = m_dones;
    step("ignore", 1'b1, 4'd4, 4'd6, 1'b0);
    for (int i = 1; i <= 7; i++)
      step("ignore", (i == 2 || i == 5), 4'd7, 4'd7, 1'b0);
    chk("ignore.result", 32'({carry_o, sum_o}), 32'd10);
    chk("ignore.pulses", 32'(m_dones - dones_before), 32'd1);

    // Asynchronous reset mid-operation
    step("abort", 1'b1, 4'd9, 4'd6, 1'b0);
    for (int i = 1; i <= 3; i++) step("abort", 1'b0, 4'd0, 4'd0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk_outputs("abort.async");
    @(posedge clk_i);
    #1;
    chk_outputs("abort.held");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("after_rst", 1'b1, 4'd2, 4'd2, 1'b0);
    drain("after_rst");
    chk("after_rst.result", 32'({carry_o, sum_o}), 32'd4);

    // start_i held high continuously
    dones_before = m_dones;
    for (int i = 0; i < 30; i++) step("held", 1'b1, 4'd1, 4'd2, 1'b0);
    drain("held");
    chk("held.result", 32'({carry_o, sum_o}), 32'd3);
    chk("held.pulses_seen", 32'(m_dones - dones_before > 2), 32'd1);

    // Random start/operand traffic
    for (int i = 0; i < 200; i++)
      step("random", ($urandom_range(0, 3) == 0), W'($urandom), W'($urandom), 1'($urandom));
    drain("random");

    // Exhaustive sweep of every operand/carry combination
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          step("sweep", 1'b1, W'(a), W'(b), 1'(c));
          for (int k = 0; k < W + 2; k++)
            step("sweep", 1'b0, W'($urandom), W'($urandom), 1'($urandom));
          chk("sweep.result", 32'({carry_o, sum_o}), 32'(a + b + c));
        end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
